// File: rtl/wb_stage.sv
// Writeback stage: selects ALU/load result for the register-file write port and
// sequences ECALLs through a req/ack/done handshake with the system-call handler,
// holding the upstream pipeline via stall_out until the a0 write-back.
// Optional build macro: WB_RETIRE_CNT_EN adds a 64-bit retire_count output.
module wb_stage #(
  parameter int DATA_WIDTH    = 64,
  parameter int REG_ID_WIDTH  = 5,
  parameter int ECALL_RET_REG = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   pc_in,
  input  logic [DATA_WIDTH-1:0]   alu_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [REG_ID_WIDTH-1:0] dest_in,
  input  logic [2:0]              wb_control_in,
  output logic                    rf_we,
  output logic [REG_ID_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  output logic                    stall_out,
  output logic                    ecall_req,
  output logic [DATA_WIDTH-1:0]   ecall_pc,
  input  logic                    ecall_ack,
  input  logic                    ecall_done,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0]             retire_count,
`endif
  input  logic [DATA_WIDTH-1:0]   ecall_ret
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [REG_ID_WIDTH-1:0] RET_REG = REG_ID_WIDTH'(ECALL_RET_REG);

  state_t                  state_q;
  logic                    ecall_req_q;
  logic [DATA_WIDTH-1:0]   ecall_pc_q;
  logic [DATA_WIDTH-1:0]   ret_q;

  logic is_ecall, reg_write, mem_to_reg;

  assign is_ecall   = wb_control_in[2];
  assign reg_write  = wb_control_in[1];
  assign mem_to_reg = wb_control_in[0];

  assign ecall_req = ecall_req_q;
  assign ecall_pc  = ecall_pc_q;

  // Write port and stall decode: normal writes are zero-latency, DONE writes a0.
  always_comb begin
    stall_out = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = dest_in;
    rf_wdata  = mem_to_reg ? mem_data_in : alu_in;
    case (state_q)
      IDLE: begin
        if (is_ecall) stall_out = 1'b1;
        else          rf_we     = reg_write && (dest_in != '0);
      end
      REQ, WAIT: stall_out = 1'b1;
      DONE: begin
        rf_we    = 1'b1;
        rf_waddr = RET_REG;
        rf_wdata = ret_q;
      end
      default: ;
    endcase
  end

  // ECALL handshake sequencer; MEM/WB is held by stall_out, so inputs are not re-sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ecall_req_q <= 1'b0;
      ecall_pc_q  <= '0;
      ret_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_ecall) begin
            ecall_pc_q  <= pc_in;
            ecall_req_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (ecall_ack) begin
            ecall_req_q <= 1'b0;
            if (ecall_done) begin
              ret_q   <= ecall_ret;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (ecall_done) begin
            ret_q   <= ecall_ret;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;
  logic [63:0] retire_cnt_d;

  assign retire_cnt_d = retire_cnt_q + 64'd1;
  assign retire_count = retire_cnt_q;

  // Every committed write (normal or a0 write-back) retires one instruction; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      retire_cnt_q <= '0;
    else if (rf_we) retire_cnt_q <= retire_cnt_d;
  end
`endif

endmodule
